da_bitserial_accum: RTL
=======================

DA_BITSERIAL_ACCUM -- requirements
Module: da_bitserial_accum

Interface
REQ-001 Parameter DW, 16: sample width, signed two's complement.
REQ-002 Parameter CW, 17: coefficient-ROM data width, signed, 14 fractional bits (FRAC=14).
REQ-003 Parameter OW, 20: output width.
REQ-004 clk  in  1  the single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 in_valid  in  1 / in_ready  out  1  input handshake; transfer when both high on a clk edge.
REQ-007 x0, x1, x2, x3  in  DW each  samples, captured on input transfer.
REQ-008 rom_cs  out  1 / rom_addr  out  3  coefficient-ROM select and address.
REQ-009 rom_data  in  CW  coefficient-ROM data, combinational (same-cycle) response to rom_addr.
REQ-010 out_valid  out  1 / out_ready  in  1  output handshake.
REQ-011 z_out  out  OW  DCT coefficient result, signed.

Function
REQ-012 FSM states: IDLE, RUN, HOLD. in_ready SHALL be 1 only in IDLE.
REQ-013 IDLE -> RUN on input transfer. Samples load into four shift registers; bit counter k = DW-1.
REQ-014 In RUN, bit slice j = k is processed MSB-first, one bit per cycle, for exactly DW cycles. rom_cs SHALL be 1 only in RUN.
REQ-015 rom_addr = {x1[j],x2[j],x3[j]} when x0[j]=0. It is the bitwise inverse of that when x0[j]=1.
REQ-016 term = sign-extended rom_data, negated when x0[j]=1.
REQ-017 Accumulator width DW+CW+1. First cycle (j=DW-1, sign slice): acc = -term. Each later cycle: acc = 2*acc + term.
REQ-018 After slice j=0, RUN -> HOLD. z_out registers acc[FRAC+OW-1:FRAC]; out_valid=1.
REQ-019 Latency: out_valid rises DW+1 cycles after the input transfer edge (17 at default).
REQ-020 HOLD -> IDLE on out_ready=1. z_out and out_valid SHALL stay stable while out_ready=0.
REQ-021 in_valid during RUN/HOLD SHALL be ignored, with no sample capture.
REQ-022 Accumulator arithmetic SHALL be wrap-free for all legal inputs.
REQ-023 Truncation of acc to OW bits SHALL be two's-complement slicing.

Reset
REQ-024 rst=1 SHALL force IDLE, acc=0, k=DW-1, shift registers=0, z_out=0, out_valid=0, rom_cs=0, rom_addr=0. in_ready=0 while rst=1, and 1 in the first cycle after release.
REQ-025 rst asserted mid-RUN or in HOLD SHALL abort the operation. No output is produced for the aborted sample set.

Configuration
REQ-026 Macro DA_ACCUM_ROUND_EN:
- Defined: z_out = (acc + 2^(FRAC-1))[FRAC+OW-1:FRAC], i.e. round-half-up.
- Undefined: plain truncation per REQ-018.

Structure
REQ-027 Shared package da_pkg SHALL hold:
- DW, CW, FRAC, OW defaults.
- The FSM state enum typedef.
- The accumulator-width constant.
REQ-028 Sub-module da_bit_slicer SHALL hold the four sample shift registers and address/negate formation (REQ-015/016). The coefficient ROM stays external and is wired by the parent.

Verification
REQ-029 x0..x3=0 -> rom_addr=000 all cycles; out_valid at cycle 17; z_out=0.
REQ-030 Single-coefficient cases:
- x3=16'h4000, others 0 -> z_out=6269 (0x187D).
- x1=16'h4000, others 0 -> z_out=15137.
REQ-031 x0=16'hC000, others 0 -> rom_addr=111 on slices 15 and 14; z_out=6269.
REQ-032 out_ready held 0 for 5 cycles after out_valid -> z_out stable, in_ready=0, rom_cs=0. in_valid pulses are ignored. One out_ready pulse -> IDLE next cycle.
REQ-033 x3=16'h0002 -> z_out=0 with DA_ACCUM_ROUND_EN undefined, z_out=1 with it defined.
REQ-034 rst pulsed at RUN cycle 8 -> all outputs 0 next edge. The next transfer yields the correct, uncontaminated result.

Source files
------------

// File: rtl/da_pkg.sv
// Shared widths and FSM state type for the bit-serial distributed-arithmetic accumulator.
package da_pkg;

    localparam int DA_DW    = 16;
    localparam int DA_CW    = 17;
    localparam int DA_FRAC  = 14;
    localparam int DA_OW    = 20;
    localparam int DA_ACC_W = DA_DW + DA_CW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } da_state_e;

endpackage

// File: rtl/da_bit_slicer.sv
// Four MSB-first sample shift registers; forms the folded ROM address and the signed ROM term.
// Address valid combinationally while run=1; shifts one bit per cycle on shift, loads on load.
module da_bit_slicer
    import da_pkg::*;
#(
    parameter int DW = DA_DW,
    parameter int CW = DA_CW,
    parameter int AW = DA_ACC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic                 run,
    input  logic [DW-1:0]        x0,
    input  logic [DW-1:0]        x1,
    input  logic [DW-1:0]        x2,
    input  logic [DW-1:0]        x3,
    input  logic [CW-1:0]        rom_data,
    output logic [2:0]           rom_addr,
    output logic signed [AW-1:0] term
);

    logic [DW-1:0]        x0_q, x0_d;
    logic [DW-1:0]        x1_q, x1_d;
    logic [DW-1:0]        x2_q, x2_d;
    logic [DW-1:0]        x3_q, x3_d;
    logic                 neg;
    logic [2:0]           addr_raw;
    logic signed [AW-1:0] rom_sext;

    always_comb begin
        x0_d = x0_q;
        x1_d = x1_q;
        x2_d = x2_q;
        x3_d = x3_q;
        if (load) begin
            x0_d = x0;
            x1_d = x1;
            x2_d = x2;
            x3_d = x3;
        end else if (shift) begin
            x0_d = {x0_q[DW-2:0], 1'b0};
            x1_d = {x1_q[DW-2:0], 1'b0};
            x2_d = {x2_q[DW-2:0], 1'b0};
            x3_d = {x3_q[DW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q <= '0;
            x1_q <= '0;
            x2_q <= '0;
            x3_q <= '0;
        end else begin
            x0_q <= x0_d;
            x1_q <= x1_d;
            x2_q <= x2_d;
            x3_q <= x3_d;
        end
    end

    // ROM is folded on x0: a set x0 bit selects the mirrored entry and flips its sign.
    always_comb begin
        neg      = x0_q[DW-1];
        addr_raw = {x1_q[DW-1], x2_q[DW-1], x3_q[DW-1]};
        rom_addr = '0;
        if (run) begin
            rom_addr = neg ? ~addr_raw : addr_raw;
        end
        rom_sext = {{(AW-CW){rom_data[CW-1]}}, rom_data};
        term     = neg ? -rom_sext : rom_sext;
    end

endmodule

// File: rtl/da_bitserial_accum.sv
// Bit-serial DA accumulator: z_out valid DW+1 cycles after input transfer, held until out_ready.
// in_ready only in IDLE; DA_ACCUM_ROUND_EN selects round-half-up instead of truncation.
module da_bitserial_accum
    import da_pkg::*;
#(
    parameter int DW   = DA_DW,
    parameter int CW   = DA_CW,
    parameter int FRAC = DA_FRAC,
    parameter int OW   = DA_OW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x0,
    input  logic [DW-1:0] x1,
    input  logic [DW-1:0] x2,
    input  logic [DW-1:0] x3,
    output logic          rom_cs,
    output logic [2:0]    rom_addr,
    input  logic [CW-1:0] rom_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] z_out
);

    localparam int AW = DW + CW + 1;
    localparam int KW = $clog2(DW);
    localparam logic [KW-1:0] K_TOP = KW'(DW - 1);
    localparam logic [AW-1:0] HALF  = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    da_state_e            state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [OW-1:0]        z_q, z_d;
    logic                 ov_q, ov_d;
    logic                 load, shift, run;
    logic signed [AW-1:0] term;
    logic [AW-1:0]        acc_out;
    logic                 unused_lsbs;

    da_bit_slicer #(
        .DW(DW),
        .CW(CW),
        .AW(AW)
    ) u_slicer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .run      (run),
        .x0       (x0),
        .x1       (x1),
        .x2       (x2),
        .x3       (x3),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .term     (term)
    );

    always_comb begin
`ifdef DA_ACCUM_ROUND_EN
        acc_out = acc_q + HALF;
`else
        acc_out = acc_q;
`endif
    end

    assign unused_lsbs = ^{acc_out[FRAC-1:0], HALF};
    assign run         = (state_q == S_RUN);
    assign rom_cs      = run;
    assign in_ready    = (state_q == S_IDLE) && !rst;
    assign out_valid   = ov_q;
    assign z_out       = z_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        z_d     = z_q;
        ov_d    = ov_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    k_d     = K_TOP;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                shift = 1'b1;
                // The MSB slice carries negative weight in two's complement.
                if (k_q == K_TOP) begin
                    acc_d = -term;
                end else begin
                    acc_d = (acc_q <<< 1) + term;
                end
                if (k_q == '0) begin
                    state_d = S_HOLD;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            S_HOLD: begin
                // First HOLD cycle registers the result; afterwards wait for the consumer.
                if (!ov_q) begin
                    z_d  = acc_out[FRAC+OW-1:FRAC];
                    ov_d = 1'b1;
                end else if (out_ready) begin
                    ov_d    = 1'b0;
                    k_d     = K_TOP;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= K_TOP;
            acc_q   <= '0;
            z_q     <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            ov_q    <= ov_d;
        end
    end

endmodule
